// File: rtl/ppl_raymarch.sv
// Fixed-step voxel ray-march stage.
// Takes one ray from the entry mux, looks up the 16x16x16 block map once per step,
// and either loops the advanced ray back through the entry mux or finishes it by
// writing one RGB565 pixel to the framebuffer.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   scanner_stop_i          entry stage is presenting dummy rays
//   start_pos_*_i           ray position, unsigned Q4.12
//   ray_slope_*_i           ray direction, signed Q4.12
//   pixel_addr_i            target pixel of the ray
//   block_cnt_i             steps already taken
//   next_en_o               request a fresh ray from the entry stage
//   end_pos_*_o, ray_slope_out_*_o, pixel_addr_out_o, block_cnt_out_o
//                           loopback values for the entry mux
//   map_addr_o, map_rd_o    block-map read request; map_data_i valid one cycle later
//   pix_we_o, pix_addr_o, pix_data_o, pix_ready_i
//                           framebuffer write with valid/ready handshake
//   busy_o                  high unless idle waiting for a fresh ray
module ppl_raymarch #(
  parameter int unsigned   MaxSteps  = 31,
  parameter int unsigned   StepShift = 2,
  parameter logic [15:0]   SkyColor  = 16'h867D
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scanner_stop_i,
  input  logic [15:0] start_pos_x_i,
  input  logic [15:0] start_pos_y_i,
  input  logic [15:0] start_pos_z_i,
  input  logic [15:0] ray_slope_x_i,
  input  logic [15:0] ray_slope_y_i,
  input  logic [15:0] ray_slope_z_i,
  input  logic [19:0] pixel_addr_i,
  input  logic [4:0]  block_cnt_i,
  output logic        next_en_o,
  output logic [15:0] end_pos_x_o,
  output logic [15:0] end_pos_y_o,
  output logic [15:0] end_pos_z_o,
  output logic [15:0] ray_slope_out_x_o,
  output logic [15:0] ray_slope_out_y_o,
  output logic [15:0] ray_slope_out_z_o,
  output logic [19:0] pixel_addr_out_o,
  output logic [4:0]  block_cnt_out_o,
  output logic [11:0] map_addr_o,
  output logic        map_rd_o,
  input  logic [7:0]  map_data_i,
  output logic        pix_we_o,
  output logic [19:0] pix_addr_o,
  output logic [15:0] pix_data_o,
  input  logic        pix_ready_i,
  output logic        busy_o
);

  localparam logic [4:0] MaxCnt = 5'(MaxSteps);

  typedef enum logic [2:0] {StLoad, StReq, StWait, StEval, StWrite} state_e;

  state_e state_q, state_d;

  // Latched ray; index 0/1/2 = x/y/z
  logic [2:0][15:0] pos_q, pos_d;
  logic [2:0][15:0] slope_q, slope_d;
  logic [19:0]      pixel_q, pixel_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [7:0]       map_data_q, map_data_d;

  // Registered outputs
  logic             next_en_q, next_en_d;
  logic [2:0][15:0] end_pos_q, end_pos_d;
  logic [2:0][15:0] slope_out_q, slope_out_d;
  logic [19:0]      pixel_addr_out_q, pixel_addr_out_d;
  logic [4:0]       block_cnt_out_q, block_cnt_out_d;
  logic [11:0]      map_addr_q, map_addr_d;
  logic             map_rd_q, map_rd_d;
  logic             pix_we_q, pix_we_d;
  logic [19:0]      pix_addr_q, pix_addr_d;
  logic [15:0]      pix_data_q, pix_data_d;
  logic             busy_q, busy_d;

  // A fresh ray cannot be taken while the scanner only offers dummy rays
  logic load_hold;
  assign load_hold = next_en_q && scanner_stop_i;

  // Candidate next position per axis. Sum range is [-0x2000, 0x11FFE], so bit 16 set
  // means the ray left the world on either side.
  logic signed [15:0] step_s [3];
  logic [2:0][16:0]   npos;
  logic               oob;
  logic               hit;
  logic               finish;

  always_comb begin
    oob = 1'b0;
    for (int a = 0; a < 3; a++) begin
      step_s[a] = $signed(slope_q[a]) >>> StepShift;
      npos[a]   = {1'b0, pos_q[a]} + {step_s[a][15], step_s[a]};
      oob       = oob | npos[a][16];
    end
  end

  assign hit    = (map_data_q != 8'd0);
  assign finish = hit || oob || (cnt_q >= MaxCnt);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (!load_hold) state_d = StReq;
      StReq:   state_d = StWait;
      StWait:  state_d = StEval;
      StEval:  state_d = finish ? StWrite : StLoad;
      StWrite: if (pix_ready_i) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    pos_d            = pos_q;
    slope_d          = slope_q;
    pixel_d          = pixel_q;
    cnt_d            = cnt_q;
    map_data_d       = map_data_q;
    next_en_d        = next_en_q;
    end_pos_d        = end_pos_q;
    slope_out_d      = slope_out_q;
    pixel_addr_out_d = pixel_addr_out_q;
    block_cnt_out_d  = block_cnt_out_q;
    map_addr_d       = map_addr_q;
    map_rd_d         = 1'b0;
    pix_we_d         = pix_we_q;
    pix_addr_d       = pix_addr_q;
    pix_data_d       = pix_data_q;

    unique case (state_q)
      StLoad: begin
        if (!load_hold) begin
          pos_d      = {start_pos_z_i, start_pos_y_i, start_pos_x_i};
          slope_d    = {ray_slope_z_i, ray_slope_y_i, ray_slope_x_i};
          pixel_d    = pixel_addr_i;
          cnt_d      = block_cnt_i;
          next_en_d  = 1'b0;
          // Lookup is issued in StReq, so its address is registered here
          map_rd_d   = 1'b1;
          map_addr_d = {start_pos_z_i[15:12], start_pos_y_i[15:12], start_pos_x_i[15:12]};
        end
      end
      StReq: ;
      StWait: map_data_d = map_data_i;
      StEval: begin
        if (hit) begin
          pix_we_d   = 1'b1;
          pix_addr_d = pixel_q;
          pix_data_d = {map_data_q, 3'b000, 5'd31 - cnt_q};
        end else if (finish) begin
          pix_we_d   = 1'b1;
          pix_addr_d = pixel_q;
          pix_data_d = SkyColor;
        end else begin
          for (int a = 0; a < 3; a++) end_pos_d[a] = npos[a][15:0];
          slope_out_d      = slope_q;
          pixel_addr_out_d = pixel_q;
          block_cnt_out_d  = cnt_q + 5'd1;
        end
      end
      StWrite: begin
        if (pix_ready_i) begin
          pix_we_d  = 1'b0;
          next_en_d = 1'b1;
        end
      end
      default: ;
    endcase

    busy_d = !((state_d == StLoad) && next_en_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q            <= '0;
      slope_q          <= '0;
      pixel_q          <= '0;
      cnt_q            <= '0;
      map_data_q       <= '0;
      next_en_q        <= 1'b1;
      end_pos_q        <= '0;
      slope_out_q      <= '0;
      pixel_addr_out_q <= '0;
      block_cnt_out_q  <= '0;
      map_addr_q       <= '0;
      map_rd_q         <= 1'b0;
      pix_we_q         <= 1'b0;
      pix_addr_q       <= '0;
      pix_data_q       <= '0;
      busy_q           <= 1'b0;
    end else begin
      pos_q            <= pos_d;
      slope_q          <= slope_d;
      pixel_q          <= pixel_d;
      cnt_q            <= cnt_d;
      map_data_q       <= map_data_d;
      next_en_q        <= next_en_d;
      end_pos_q        <= end_pos_d;
      slope_out_q      <= slope_out_d;
      pixel_addr_out_q <= pixel_addr_out_d;
      block_cnt_out_q  <= block_cnt_out_d;
      map_addr_q       <= map_addr_d;
      map_rd_q         <= map_rd_d;
      pix_we_q         <= pix_we_d;
      pix_addr_q       <= pix_addr_d;
      pix_data_q       <= pix_data_d;
      busy_q           <= busy_d;
    end
  end

  assign next_en_o         = next_en_q;
  assign end_pos_x_o       = end_pos_q[0];
  assign end_pos_y_o       = end_pos_q[1];
  assign end_pos_z_o       = end_pos_q[2];
  assign ray_slope_out_x_o = slope_out_q[0];
  assign ray_slope_out_y_o = slope_out_q[1];
  assign ray_slope_out_z_o = slope_out_q[2];
  assign pixel_addr_out_o  = pixel_addr_out_q;
  assign block_cnt_out_o   = block_cnt_out_q;
  assign map_addr_o        = map_addr_q;
  assign map_rd_o          = map_rd_q;
  assign pix_we_o          = pix_we_q;
  assign pix_addr_o        = pix_addr_q;
  assign pix_data_o        = pix_data_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_ppl_raymarch.sv
// Self-checking bench for ppl_raymarch: models the entry mux, scanner and block map;
// expected pixels are queued per ray and checked by an independent monitor.
module tb_ppl_raymarch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        scanner_stop;
  logic        pix_ready;
  logic [7:0]  map_data;
  logic [15:0] sc_px, sc_py, sc_pz, sc_sx, sc_sy, sc_sz;
  logic [19:0] sc_addr;

  logic        next_en, map_rd, pix_we, busy;
  logic [15:0] end_pos_x, end_pos_y, end_pos_z;
  logic [15:0] slope_out_x, slope_out_y, slope_out_z;
  logic [19:0] pixel_addr_out, pix_addr;
  logic [4:0]  block_cnt_out;
  logic [11:0] map_addr;
  logic [15:0] pix_data;

  // Entry mux: fresh scanner ray when next_en, otherwise loopback
  logic [15:0] in_px, in_py, in_pz, in_sx, in_sy, in_sz;
  logic [19:0] in_addr;
  logic [4:0]  in_cnt;
  assign in_px   = next_en ? sc_px : end_pos_x;
  assign in_py   = next_en ? sc_py : end_pos_y;
  assign in_pz   = next_en ? sc_pz : end_pos_z;
  assign in_sx   = next_en ? sc_sx : slope_out_x;
  assign in_sy   = next_en ? sc_sy : slope_out_y;
  assign in_sz   = next_en ? sc_sz : slope_out_z;
  assign in_addr = next_en ? sc_addr : pixel_addr_out;
  assign in_cnt  = next_en ? 5'd0 : block_cnt_out;

  ppl_raymarch dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .scanner_stop_i    (scanner_stop),
    .start_pos_x_i     (in_px),
    .start_pos_y_i     (in_py),
    .start_pos_z_i     (in_pz),
    .ray_slope_x_i     (in_sx),
    .ray_slope_y_i     (in_sy),
    .ray_slope_z_i     (in_sz),
    .pixel_addr_i      (in_addr),
    .block_cnt_i       (in_cnt),
    .next_en_o         (next_en),
    .end_pos_x_o       (end_pos_x),
    .end_pos_y_o       (end_pos_y),
    .end_pos_z_o       (end_pos_z),
    .ray_slope_out_x_o (slope_out_x),
    .ray_slope_out_y_o (slope_out_y),
    .ray_slope_out_z_o (slope_out_z),
    .pixel_addr_out_o  (pixel_addr_out),
    .block_cnt_out_o   (block_cnt_out),
    .map_addr_o        (map_addr),
    .map_rd_o          (map_rd),
    .map_data_i        (map_data),
    .pix_we_o          (pix_we),
    .pix_addr_o        (pix_addr),
    .pix_data_o        (pix_data),
    .pix_ready_i       (pix_ready),
    .busy_o            (busy)
  );

  // Block map: data valid the cycle after map_rd, garbage otherwise
  logic [7:0] mem [4096];
  always @(posedge clk) map_data <= map_rd ? mem[map_addr] : 8'hA5;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    int          lookups;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] epos_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          load_cyc = 0;
  int          nlook = 0;
  bit          we_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: per-lookup loopback checks, write latency and pixel scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (map_rd) begin
        chk("next_en low during ray", next_en, 0);
        if (nlook > 0) begin
          chk("block_cnt_out", block_cnt_out, nlook);
          if (sb_q.size() > 0) chk("pixel_addr_out", pixel_addr_out, sb_q[0].addr);
          if (epos_q.size() > 0) begin
            chk("end_pos_x", end_pos_x, epos_q[0]);
            void'(epos_q.pop_front());
          end
        end
        nlook++;
      end
      if (pix_we && !we_seen) begin
        we_seen = 1;
        if (sb_q.size() > 0) chk("pix_we latency", cyc - load_cyc, 4 * sb_q[0].lookups);
      end
      if (pix_we && pix_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious pix_we", pix_we, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pix_addr", pix_addr, mon_e.addr);
          chk("pix_data", pix_data, mon_e.data);
          chk("lookups", nlook, mon_e.lookups);
        end
        nlook   = 0;
        we_seen = 0;
      end
    end
  end

  task automatic clear_map();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic run_ray(input logic [15:0] px, py, pz, sx, sy, sz, input logic [19:0] addr,
                         input logic [15:0] exp_data, input int lookups, input bit bp);
    exp_t te;
    bit   got;
    te.addr = addr; te.data = exp_data; te.lookups = lookups;
    @(posedge clk); #1;
    sb_q.push_back(te);
    sc_px = px; sc_py = py; sc_pz = pz; sc_sx = sx; sc_sy = sy; sc_sz = sz; sc_addr = addr;
    if (bp) pix_ready = 1'b0;
    scanner_stop = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (next_en) got = 1;
    end
    if (!got) chk("next_en before load", next_en, 1);
    load_cyc = cyc;
    @(posedge clk); #1 scanner_stop = 1'b1;
    if (bp) begin
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (pix_we) got = 1;
      end
      for (int i = 0; i < 10; i++) begin
        chk("bp pix_we", pix_we, 1);
        chk("bp pix_addr", pix_addr, addr);
        chk("bp pix_data", pix_data, exp_data);
        chk("bp next_en", next_en, 0);
        @(negedge clk);
      end
      @(posedge clk); #1 pix_ready = 1'b1;
    end
    for (int i = 0; i < 400 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      chk("write timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clk);
    chk("next_en after ray", next_en, 1);
    chk("pix_we after ray", pix_we, 0);
  endtask

  initial begin
    rst_n = 1'b0; scanner_stop = 1'b1; pix_ready = 1'b1;
    sc_px = '0; sc_py = '0; sc_pz = '0; sc_sx = '0; sc_sy = '0; sc_sz = '0; sc_addr = '0;
    clear_map();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst next_en", next_en, 1);
    chk("rst pix_we", pix_we, 0);
    chk("rst map_rd", map_rd, 0);
    chk("rst busy", busy, 0);
    chk("rst end_pos", {end_pos_x, end_pos_y}, 0);
    chk("rst end_pos_z", end_pos_z, 0);
    chk("rst slope_out", {slope_out_x, slope_out_y}, 0);
    chk("rst loop addr/cnt", {pixel_addr_out, block_cnt_out}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // First-lookup hit
    mem[12'h111] = 8'h05;
    run_ray(16'h1000, 16'h1000, 16'h1000, 0, 0, 0, 20'h00500, 16'h051F, 1, 0);

    // Stepping along x until cell 2
    clear_map();
    mem[12'h002] = 8'h03;
    epos_q = '{16'h1400, 16'h1800, 16'h1C00, 16'h2000};
    run_ray(16'h1000, 16'h0000, 16'h0000, 16'h1000, 0, 0, 20'h12345, 16'h031B, 5, 0);
    chk("epos consumed", epos_q.size(), 0);

    // Leaving the world on +x
    clear_map();
    run_ray(16'hFF00, 16'h0000, 16'h0000, 16'h1000, 0, 0, 20'h00777, 16'h867D, 1, 0);
    chk("no loopback update", end_pos_x, 16'h2000);

    // Leaving the world on -x (negative slope)
    run_ray(16'h0100, 16'h0000, 16'h0000, 16'hF000, 0, 0, 20'h00778, 16'h867D, 1, 0);

    // Step budget exhausted
    run_ray(16'h8000, 16'h8000, 16'h8000, 0, 0, 0, 20'hABCDE, 16'h867D, 32, 0);
    chk("budget end_pos_y", end_pos_y, 16'h8000);

    // Backpressure during write
    mem[12'h345] = 8'h7A;
    run_ray(16'h5000, 16'h4000, 16'h3000, 0, 0, 0, 20'h0BEEF, 16'h7A1F, 1, 1);

    // Scanner stop holds the stage idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stop map_rd", map_rd, 0);
      chk("stop pix_we", pix_we, 0);
      chk("stop next_en", next_en, 1);
      chk("stop busy", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
